// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    // Receiver frame phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // s_tick pulses per bit period.
    localparam int OVERSAMPLE  = 16;

    // Default frame shape: 8 data bits, one stop bit.
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

    // Tick counter values: middle of a bit and last tick of a bit.
    localparam int MID_TICK    = OVERSAMPLE / 2 - 1;
    localparam int LAST_TICK   = OVERSAMPLE - 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // Shift the async input through two flops; reset parks both at RST_VAL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ff_q <= {2{RST_VAL}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, DBIT data bits, configurable
// stop length. Produces a one-clk rx_done_tick with dout/framing_err held
// until the next completed frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       framing_err
);

    // The tick counter is 5 bits so STOP can reach SB_TICK-1 (up to 31);
    // START and DATA never take it past 15.
    localparam logic [4:0] S_MID      = 5'(MID_TICK);
    localparam logic [4:0] S_LAST     = 5'(LAST_TICK);
    localparam logic [4:0] S_STOP_END = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST     = 3'(DBIT - 1);

    logic       rx_s;
    state_t     state_q;
    logic [4:0] s_q;
    logic [2:0] n_q;
    logic [7:0] b_q;
    logic [7:0] b_d;
    logic       stop_smp_q;
    logic       done_q;
    logic [7:0] dout_q;
    logic       ferr_q;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // Next data word: shift right and drop the new bit into the top data
    // position, so after DBIT shifts the first bit sits in bit 0. With
    // DBIT=7 bit 7 only ever receives zeros.
    always_comb begin
        b_d         = b_q >> 1;
        b_d[DBIT-1] = rx_s;
    end

    // Frame FSM with tick/bit counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            s_q        <= '0;
            n_q        <= '0;
            b_q        <= '0;
            stop_smp_q <= 1'b1;
            done_q     <= 1'b0;
            dout_q     <= '0;
            ferr_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Start-bit edge is taken immediately, not on a tick.
                    if (!rx_s) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == S_MID) begin
                            if (!rx_s) begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                // Line back high at mid start bit: a glitch.
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            b_q <= b_d;
                            if (n_q == N_LAST) begin
                                state_q <= STOP;
                            end else begin
                                n_q <= n_q + 3'd1;
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_q == S_MID) begin
                            stop_smp_q <= rx_s;
                        end
                        if (s_q == S_STOP_END) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            dout_q  <= b_q;
                            ferr_q  <= ~stop_smp_q;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign framing_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 instance and a 7-bit/2-stop
// instance, each compared every cycle against a tick-index frame model.
module tb_uart_rx;

    localparam int TICKP  = 5;            // clk per s_tick
    localparam int BITCLK = 16 * TICKP;   // clk per serial bit

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick = 1'b0;
    logic       rx8;
    logic       rx7;
    logic       done8, done7, ferr8, ferr7;
    logic [7:0] dout8, dout7;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_start = 0;
    int done7_cyc = 0;

    logic [7:0] q8d[$];
    logic       q8f[$];
    logic [7:0] q7d[$];
    logic       q7f[$];

    always #5 clk = ~clk;

    uart_rx dut8 (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx8),
        .rx_done_tick(done8),
        .dout        (dout8),
        .framing_err (ferr8)
    );

    uart_rx #(
        .DBIT   (7),
        .SB_TICK(32)
    ) dut7 (
        .clk         (clk),
        .reset       (reset),
        .s_tick      (s_tick),
        .rx          (rx7),
        .rx_done_tick(done7),
        .dout        (dout7),
        .framing_err (ferr7)
    );

    // Tick on every posedge whose index is a multiple of TICKP.
    always @(negedge clk) s_tick = (((cyc + 1) % TICKP) == 0);

    // ---------------- behavioural model ----------------
    // Frame positions are counted as s_tick indices after start detection:
    // start check at 8, data bit k at 8+16(k+1), stop sample at 8+16*DBIT+8,
    // frame end at 8+16*DBIT+SB_TICK.
    logic       m_sy1[2], m_sy2[2], m_busy[2], m_stop[2], m_done[2], m_ferr[2];
    int         m_t[2];
    logic [7:0] m_bits[2], m_dout[2];

    task automatic model_step(input int k, input int dbit, input int sbt, input logic rxi);
        logic rxs;
        int   last;
        if (reset !== 1'b1) begin
            m_sy1[k] = 1'b1; m_sy2[k] = 1'b1; m_busy[k] = 1'b0; m_t[k] = 0;
            m_done[k] = 1'b0; m_dout[k] = 8'h00; m_ferr[k] = 1'b0; m_stop[k] = 1'b1;
            return;
        end
        m_done[k] = 1'b0;
        rxs = m_sy2[k];
        m_sy2[k] = m_sy1[k];
        m_sy1[k] = rxi;
        last = 8 + 16 * dbit;
        if (!m_busy[k]) begin
            if (rxs == 1'b0) begin
                m_busy[k] = 1'b1; m_t[k] = 0; m_bits[k] = 8'h00;
            end
        end else if (s_tick) begin
            m_t[k]++;
            if (m_t[k] == 8) begin
                if (rxs == 1'b1) m_busy[k] = 1'b0;
            end else if (m_t[k] > 8 && m_t[k] <= last) begin
                if (((m_t[k] - 8) % 16) == 0) m_bits[k][(m_t[k] - 8) / 16 - 1] = rxs;
            end else if (m_t[k] > last) begin
                if (m_t[k] == last + 8) m_stop[k] = rxs;
                if (m_t[k] == last + sbt) begin
                    m_busy[k] = 1'b0; m_done[k] = 1'b1;
                    m_dout[k] = m_bits[k]; m_ferr[k] = ~m_stop[k];
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, 8, 16, rx8);
        model_step(1, 7, 32, rx7);
    end

    // ---------------- checking helpers ----------------
    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, plus capture of completed frames.
    always @(posedge clk) begin
        #1;
        chk1("done8", done8, m_done[0]);
        chk8("dout8", dout8, m_dout[0]);
        chk1("ferr8", ferr8, m_ferr[0]);
        chk1("done7", done7, m_done[1]);
        chk8("dout7", dout7, m_dout[1]);
        chk1("ferr7", ferr7, m_ferr[1]);
        if (done8 === 1'b1) begin q8d.push_back(dout8); q8f.push_back(ferr8); end
        if (done7 === 1'b1) begin q7d.push_back(dout7); q7f.push_back(ferr7); done7_cyc = cyc; end
    end

    task automatic expect_frame(input bit w, input string nm, input logic [7:0] d, input logic f);
        logic [7:0] ad;
        logic       af;
        if ((w ? q7d.size() : q8d.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no rx_done_tick, expected dout=%02h ferr=%b", nm, d, f);
        end else begin
            if (w) begin ad = q7d.pop_front(); af = q7f.pop_front(); end
            else   begin ad = q8d.pop_front(); af = q8f.pop_front(); end
            chk8({nm, "_dout"}, ad, d);
            chk1({nm, "_ferr"}, af, f);
        end
    endtask

    task automatic expect_none(input bit w, input string nm);
        chki(nm, w ? q7d.size() : q8d.size(), 0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit w, input logic v);
        if (w) rx7 = v; else rx8 = v;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Place the start edge so the receiver's tick grid is centred on bits.
    task automatic align_start();
        while (((cyc + 3) % TICKP) != 0) @(negedge clk);
    endtask

    task automatic send_frame(input bit w, input logic [7:0] d, input int dbit,
                              input logic stopv, input int stop_clks);
        align_start();
        t_start = cyc;
        drive(w, 1'b0);
        wait_clk(BITCLK);
        for (int k = 0; k < dbit; k++) begin
            drive(w, d[k]);
            wait_clk(BITCLK);
        end
        drive(w, stopv);
        wait_clk(stop_clks);
    endtask

    // Hard bound on run length.
    initial begin
        repeat (95000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] dv;
        logic [7:0] rd;
        bit         rw;
        bit         good;

        reset = 1'b0;
        rx8   = 1'b1;
        rx7   = 1'b1;
        wait_clk(4);
        chk1("rst_done8", done8, 1'b0);
        chk8("rst_dout8", dout8, 8'h00);
        chk1("rst_ferr8", ferr8, 1'b0);
        chk8("rst_dout7", dout7, 8'h00);
        reset = 1'b1;
        wait_clk(2 * BITCLK);

        // Clean 8N1 frame.
        send_frame(0, 8'h55, 8, 1'b1, BITCLK);
        wait_clk(2 * BITCLK);
        expect_frame(0, "f55", 8'h55, 1'b0);
        expect_none(0, "f55_single");

        // Stop bit low, then line held low: one break frame follows.
        send_frame(0, 8'hA3, 8, 1'b0, BITCLK);
        wait_clk(9 * BITCLK + 4 * TICKP);
        rx8 = 1'b1;
        wait_clk(3 * BITCLK);
        expect_frame(0, "fA3", 8'hA3, 1'b1);
        expect_frame(0, "brk", 8'h00, 1'b1);
        expect_none(0, "brk_end");

        // Short low glitch is rejected; receiver still works afterwards.
        align_start();
        rx8 = 1'b0;
        wait_clk(4 * TICKP);
        rx8 = 1'b1;
        wait_clk(2 * BITCLK);
        expect_none(0, "glitch");
        send_frame(0, 8'h96, 8, 1'b1, BITCLK);
        wait_clk(BITCLK);
        expect_frame(0, "f96", 8'h96, 1'b0);

        // Reset in the middle of data bit 3 of 0xC4, then a clean frame.
        dv = 8'hC4;
        align_start();
        rx8 = 1'b0;
        wait_clk(BITCLK);
        for (int k = 0; k < 3; k++) begin
            rx8 = dv[k];
            wait_clk(BITCLK);
        end
        rx8 = dv[3];
        wait_clk(BITCLK / 2);
        reset = 1'b0;
        rx8   = 1'b1;
        wait_clk(2);
        reset = 1'b1;
        wait_clk(2 * BITCLK);
        expect_none(0, "abort_C4");
        send_frame(0, 8'h3C, 8, 1'b1, BITCLK);
        wait_clk(2 * BITCLK);
        expect_frame(0, "f3C", 8'h3C, 1'b0);
        expect_none(0, "f3C_single");

        // Back-to-back frames without idle gap.
        send_frame(0, 8'h00, 8, 1'b1, BITCLK);
        send_frame(0, 8'hFF, 8, 1'b1, BITCLK);
        wait_clk(2 * BITCLK);
        expect_frame(0, "b2b_00", 8'h00, 1'b0);
        expect_frame(0, "b2b_FF", 8'hFF, 1'b0);
        expect_none(0, "b2b_count");

        // 7 data bits, two stop bits: completion 152 ticks after detection.
        send_frame(1, 8'h41, 7, 1'b1, 2 * BITCLK);
        wait_clk(BITCLK);
        expect_frame(1, "f41", 8'h41, 1'b0);
        chki("f41_latency", done7_cyc - t_start, 3 + 152 * TICKP);

        // Randomized frames on both instances, occasionally with a bad stop.
        for (int i = 0; i < 30; i++) begin
            rw   = 1'($urandom_range(0, 1));
            rd   = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            if (rw) rd[7] = 1'b0;
            send_frame(rw, rd, rw ? 7 : 8, good,
                       good ? (rw ? 2 * BITCLK : BITCLK) : BITCLK / 2);
            drive(rw, 1'b1);
            wait_clk(BITCLK + $urandom_range(0, 40));
            expect_frame(rw, "rnd", rd, !good);
        end
        expect_none(0, "rnd_end8");
        expect_none(1, "rnd_end7");

        wait_clk(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, meaning data bits per frame; legal values 7 and 8.
REQ-002 Parameter SB_TICK, default 16, meaning stop-bit length in s_tick periods; legal values 16, 24 and 32 (1, 1.5 and 2 stop bits).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 s_tick  input  1  one-clk enable pulse at 16x baud, from the baud-tick generator.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 rx_done_tick  output  1  one-clk pulse; a frame has completed.
REQ-008 dout  output  8  received data word.
REQ-009 framing_err  output  1  stop bit was sampled low for the last frame.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer before any use; the synchronizer resets to 1; this adds 2 clk of latency.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP, a 4-bit tick counter s, and a 3-bit bit counter n.
REQ-012 IDLE: when synchronized rx is 0, the FSM SHALL go to START with s=0; this does not wait for s_tick.
REQ-013 START: on each s_tick, if s==7 and rx==0, the FSM SHALL go to DATA with s=0 and n=0.
REQ-014 START: on an s_tick with s==7 and rx==1 (glitch), the FSM SHALL return to IDLE with no output change.
REQ-015 START: on any other s_tick, s SHALL increment.
REQ-016 DATA: on an s_tick with s==15, rx SHALL be shifted into the data register LSB-first and s SHALL be set to 0.
REQ-017 DATA: after that shift, the FSM SHALL go to STOP if n==DBIT-1; otherwise n SHALL increment.
REQ-018 DATA: on any other s_tick, s SHALL increment.
REQ-019 STOP: rx SHALL be sampled on the s_tick where s==7, and the sampled value SHALL be held internally.
REQ-020 STOP: on the s_tick where s==SB_TICK-1, the FSM SHALL go to IDLE.
REQ-021 STOP: s SHALL be wide enough to count to SB_TICK-1 (5 bits internally); the 4-bit rule in REQ-011 applies to the other states.
REQ-022 rx_done_tick SHALL be registered and high for exactly one clk, in the cycle after the final STOP s_tick.
REQ-023 dout and framing_err SHALL update in that same cycle and hold until the next rx_done_tick.
REQ-024 framing_err SHALL equal the inverse of the STOP mid-bit sample.
REQ-025 dout[DBIT-1:0] SHALL hold the data with the first received bit in dout[0]; when DBIT=7, dout[7] SHALL be 0.
REQ-026 In every state, cycles without s_tick SHALL leave s, n and the state unchanged.
REQ-027 A break (rx held low) SHALL yield repeated frames of 0x00 with framing_err=1; the block has no lock-up state.
REQ-028 No overrun detection SHALL exist; the consumer captures dout on rx_done_tick.

Reset
REQ-029 While reset==0 at a clk edge, the FSM SHALL enter IDLE, with s=0 and n=0.
REQ-030 While reset==0, the data register, dout, rx_done_tick and framing_err SHALL be 0, and the synchronizer SHALL be 1.
REQ-031 A reset during any state SHALL abandon the frame without producing rx_done_tick.

Structure
REQ-032 Package uart_pkg SHALL hold the state enum typedef (IDLE, START, DATA, STOP), OVERSAMPLE=16, and the default DBIT/SB_TICK constants.
REQ-033 The synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter; all other logic stays in uart_rx.

Verification (100 MHz clk; s_tick every 651 clk, about 9600 baud x16)
REQ-034 8N1 frame 0x55 -> exactly one rx_done_tick, dout=0x55, framing_err=0.
REQ-035 Frame 0xA3 with the stop bit held 0 -> dout=0xA3, framing_err=1; with rx kept low afterwards, the next frame gives 0x00 and framing_err=1.
REQ-036 rx low for 4 s_tick periods, then high -> no rx_done_tick, and the FSM is back in IDLE by the 8th tick.
REQ-037 reset=0 for 2 clk during data bit 3 of 0xC4, then a clean frame 0x3C -> no pulse for the aborted frame, then dout=0x3C.
REQ-038 Back-to-back frames 0x00 and 0xFF with no idle gap -> two rx_done_tick pulses, dout 0x00 then 0xFF.
REQ-039 DBIT=7, SB_TICK=32, frame 0x41 -> dout=0x41, framing_err=0, and rx_done_tick occurs 32 ticks after the stop-bit start.
